lms_fir_datapath: RTL
=====================

# lms_fir_datapath

Adaptive FIR datapath that feeds the `lms` weight-update block. It accepts one input sample and one desired sample per transaction, shifts the sample into a TAPS-deep delay line, and computes `y = Σ w[i]·x[i]` with a serial multiply-accumulate. It then produces `error = d − y` and a snapshot of the delay line. The error and the snapshot drive the `error` and `din` inputs of `lms`, whose `next_weights` return as `curr_weights` for the next sample.

## Interface
- `WIDTH`, 16, sample/weight/error width, signed two's complement
- `TAPS`, 16, filter length, ≥2
- `FRAC`, 15, fractional bits of every operand (Q(WIDTH−FRAC).FRAC)
- `clk`  in  1  sole clock, rising edge
- `rst_n`  in  1  reset, asynchronous assert, active-low
- `in_valid`  in  1  sample offered
- `in_ready`  out  1  datapath can accept
- `x_in`  in  WIDTH  new input sample
- `d_in`  in  WIDTH  desired sample
- `curr_weights`  in  TAPS×WIDTH  packed weights, `[TAPS-1:0][WIDTH-1:0]`
- `out_valid`  out  1  result held
- `out_ready`  in  1  consumer accepts result
- `y_out`  out  WIDTH  filter output
- `error_out`  out  WIDTH  `d − y`, saturated
- `taps_out`  out  TAPS×WIDTH  delay line used for this result; `taps_out[0]` is the newest sample

## Operation
- One clock. Reset is asynchronous and active-low: `rst_n` low forces state IDLE, zeroes the delay line, weight shadow, accumulator, `y_out`, `error_out` and `taps_out`, and sets `out_valid=0` and `in_ready=0`. `in_ready` is 1 from the first edge after reset release.
- FSM states:
  - IDLE: `in_ready=1`. On `in_valid`, the accept edge:
    - shifts the delay line (`x[0]←x_in`, `x[i]←x[i−1]`);
    - latches `d_in`;
    - copies `curr_weights` into a shadow register;
    - clears the accumulator and index;
    - goes to MAC.
  - MAC: each cycle, `acc += w[k]·x[k]` for k = 0..TAPS−1. After k = TAPS−1, goes to ROUND.
  - ROUND: computes the scaled, saturated `y` and `error` (rules below), registers them into `y_out` and `error_out`, copies the delay line into `taps_out`, and goes to DONE.
  - DONE: `out_valid=1`, outputs held stable. When `out_ready=1`, goes to IDLE.
- `in_ready` is 0 in MAC, ROUND and DONE. An `in_valid` there is ignored, and `x_in`/`d_in` are not sampled.
- `curr_weights` is sampled only on the accept edge. Changes during MAC do not affect the current result.
- Arithmetic:
  - Products are 2·WIDTH bits, signed.
  - The accumulator is 2·WIDTH+$clog2(TAPS) bits and never overflows.
  - `y` = acc scaled right by FRAC (arithmetic shift), then saturated to WIDTH bits signed (max 0x7FFF, min 0x8000 at WIDTH=16).
  - `error` = `d − y` computed in WIDTH+1 bits, then saturated to WIDTH bits.
- Boundaries:
  - The first samples after reset see a zero-filled delay line.
  - `out_ready` held low keeps DONE and all outputs indefinitely.
  - Reset mid-MAC or in DONE discards the transaction with no output.

## Timing
- Accept at edge E0. MAC spans edges E1..E_TAPS. `out_valid` rises after edge E_TAPS+1.
- With `out_ready=1` on the first DONE cycle, the handshake completes at E_TAPS+2 and `in_ready` is 1 after it. The next accept is earliest at E_TAPS+3.
- Maximum throughput is therefore one sample per TAPS+3 cycles.
- All outputs are registered, with no combinational input-to-output paths.

## Configuration
- `LMS_FIR_ROUND_EN` defined: round-half-up before the scale. `y = (acc + 2^(FRAC−1)) >>> FRAC`, then saturate.
- `LMS_FIR_ROUND_EN` undefined: truncation toward −∞. `y = acc >>> FRAC`, then saturate.
- All other behaviour and all latencies are identical in both builds.

## Test plan
All scenarios use TAPS=4, WIDTH=16, FRAC=15.
- **Basic product:** after reset, weights all 0x4000, accept x=0x4000, d=0x6000 → `y_out=0x2000`, `error_out=0x4000`, `taps_out={0,0,0,0x4000}`. `out_valid` rises after edge 5 from accept.
- **Saturation:** weights all 0x7FFF, accept x=0x7FFF four times with d=0x8000. Fourth result: `y_out=0x7FFF` (saturated), `error_out=0x8000` (saturated).
- **Rounding:** `w[0]=0x0001`, others 0, x=0x4000 → `y_out=0x0001` with the macro, 0x0000 without. With `w[0]=0xFFFF` → 0x0000 with the macro, 0xFFFF without.
- **Backpressure:** hold `out_ready=0` for 10 cycles in DONE while toggling `curr_weights` and `in_valid` → outputs stable, `in_ready=0`, no new sample shifted in. Release → next accept lands exactly 1 cycle after the handshake.
- **Weight isolation:** change `curr_weights` from 0x4000 to 0x0000 one cycle after accept → result still uses 0x4000.
- **Reset mid-MAC:** pulse `rst_n` low during MAC → `out_valid` stays 0, and the next transaction's `taps_out` shows a zero-filled history.

Source files
------------

// File: rtl/lms_fir_datapath.sv
// Adaptive FIR datapath: delay line, serial MAC, scaled/saturated y and d - y.
// Define LMS_FIR_ROUND_EN for round-half-up scaling; otherwise y truncates toward -inf.
module lms_fir_datapath #(
    parameter int WIDTH = 16,
    parameter int TAPS  = 16,
    parameter int FRAC  = 15
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [WIDTH-1:0]            x_in,
    input  logic [WIDTH-1:0]            d_in,
    input  logic [TAPS-1:0][WIDTH-1:0]  curr_weights,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [WIDTH-1:0]            y_out,
    output logic [WIDTH-1:0]            error_out,
    output logic [TAPS-1:0][WIDTH-1:0]  taps_out
);

    localparam int IW = $clog2(TAPS);
    localparam int AW = 2 * WIDTH + IW;

    localparam logic signed [AW:0] YMAX =
        {{(AW - WIDTH + 2){1'b0}}, {(WIDTH - 1){1'b1}}};
    localparam logic signed [AW:0] YMIN = ~YMAX;

`ifdef LMS_FIR_ROUND_EN
    localparam logic signed [AW:0] RND = (AW + 1)'(1) << (FRAC - 1);
`else
    localparam logic signed [AW:0] RND = '0;
`endif

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        ROUND,
        DONE
    } state_t;

    state_t                       state;
    logic [TAPS-1:0][WIDTH-1:0]   x_q;
    logic [TAPS-1:0][WIDTH-1:0]   w_q;
    logic [WIDTH-1:0]             d_q;
    logic signed [AW-1:0]         acc;
    logic [IW-1:0]                k;

    logic signed [2*WIDTH-1:0]    prod;
    logic signed [AW:0]           rsum;
    logic signed [AW:0]           scaled;
    logic [WIDTH-1:0]             y_sat;
    logic [WIDTH:0]               diff;
    logic [WIDTH-1:0]             e_sat;

    assign prod   = $signed(w_q[k]) * $signed(x_q[k]);
    assign rsum   = {acc[AW-1], acc} + RND;
    assign scaled = rsum >>> FRAC;
    assign diff   = {d_q[WIDTH-1], d_q} - {y_sat[WIDTH-1], y_sat};

    always_comb begin
        y_sat = scaled[WIDTH-1:0];
        if (scaled > YMAX) begin
            y_sat = {1'b0, {(WIDTH - 1){1'b1}}};
        end else if (scaled < YMIN) begin
            y_sat = {1'b1, {(WIDTH - 1){1'b0}}};
        end
    end

    // Sign bits disagree only when d - y left the WIDTH-bit range.
    always_comb begin
        e_sat = diff[WIDTH-1:0];
        if (diff[WIDTH] != diff[WIDTH-1]) begin
            e_sat = {diff[WIDTH], {(WIDTH - 1){~diff[WIDTH]}}};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            x_q       <= '0;
            w_q       <= '0;
            d_q       <= '0;
            acc       <= '0;
            k         <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            y_out     <= '0;
            error_out <= '0;
            taps_out  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    in_ready <= 1'b1;
                    if (in_valid && in_ready) begin
                        x_q      <= {x_q[TAPS-2:0], x_in};
                        d_q      <= d_in;
                        w_q      <= curr_weights;
                        acc      <= '0;
                        k        <= '0;
                        in_ready <= 1'b0;
                        state    <= MAC;
                    end
                end
                MAC: begin
                    acc <= acc + AW'(prod);
                    k   <= k + 1'b1;
                    if (k == IW'(TAPS - 1)) begin
                        state <= ROUND;
                    end
                end
                ROUND: begin
                    y_out     <= y_sat;
                    error_out <= e_sat;
                    taps_out  <= x_q;
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule
